act_read_sequencer: RTL and testbench

Sequences reads from the activation buffer's read-only port and streams the returned 128-bit activation vectors to the PE array over a valid/ready handshake. Generates a strided address pattern, optionally repeated over several passes for activation reuse. Absorbs the buffer's 1-cycle read latency with a 2-entry output FIFO and credit-based issue, so it sustains one vector per cycle. Sits between the layer controller (configuration and start) and the act_buffer/PE array datapath.

---
 rtl/act_read_sequencer.sv | 156 +++++++++++++++
 tb/tb_act_read_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_read_sequencer.sv
`default_nettype none
// =====================================================================================
// act_read_sequencer -- strided act_buffer reader streaming vectors to the PE array (rev 1.0)
// =====================================================================================
module act_read_sequencer #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [LEN_WIDTH-1:0]  cfg_passes,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic                  buf_rd,
  input  logic [DATA_WIDTH-1:0] buf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] base_q, stride_q, addr_acc, addr_last;
  logic [LEN_WIDTH-1:0]  len_q, passes_q, vec_idx, pass_idx;

  logic                  inflight, inflight_last, inflight_final;
  logic [DATA_WIDTH-1:0] mem [2];
  logic [1:0]            mem_last, mem_final;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;

  logic       accept, issue, pop, vec_end, pass_end, cfg_empty, head_final;
  logic [2:0] occupancy;

  assign accept     = (state == S_IDLE) && start && !abort;
  assign cfg_empty  = (cfg_len == '0) || (cfg_passes == '0);
  assign vec_end    = (vec_idx == len_q - 1'b1);
  assign pass_end   = (pass_idx == passes_q - 1'b1);

  assign out_valid  = (count != 2'd0);
  assign pop        = out_valid && out_ready;
  assign out_data   = mem[rd_ptr];
  assign out_last   = mem_last[rd_ptr];
  assign head_final = mem_final[rd_ptr];

  // Credit check: entries that will occupy the FIFO next cycle must leave room for this issue.
  assign occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == S_RUN) && !abort && (occupancy < 3'd2);

  assign buf_rd     = issue;
  assign buf_addr   = issue ? addr_acc : addr_last;
  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = cfg_empty ? S_DONE : S_RUN;
      S_RUN:   if (issue && vec_end && pass_end) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && head_final) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Address generation by accumulation; each pass restarts at the latched base.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      passes_q  <= '0;
      addr_acc  <= '0;
      addr_last <= '0;
      vec_idx   <= '0;
      pass_idx  <= '0;
    end else if (abort) begin
      addr_acc  <= '0;
      vec_idx   <= '0;
      pass_idx  <= '0;
    end else if (accept) begin
      base_q    <= cfg_base;
      stride_q  <= cfg_stride;
      len_q     <= cfg_len;
      passes_q  <= cfg_passes;
      addr_acc  <= cfg_base;
      vec_idx   <= '0;
      pass_idx  <= '0;
    end else if (issue) begin
      addr_last <= addr_acc;
      if (vec_end) begin
        vec_idx  <= '0;
        pass_idx <= pass_idx + 1'b1;
        addr_acc <= base_q;
      end else begin
        vec_idx  <= vec_idx + 1'b1;
        addr_acc <= addr_acc + stride_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      inflight       <= 1'b0;
      inflight_last  <= 1'b0;
      inflight_final <= 1'b0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      count          <= 2'd0;
    end else begin
      inflight       <= issue;
      inflight_last  <= issue && vec_end;
      inflight_final <= issue && vec_end && pass_end;
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      count          <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // Each entry carries the pass-end tag and a run-end tag used to detect the final handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      mem_last  <= '0;
      mem_final <= '0;
    end else if (inflight && !abort) begin
      mem[wr_ptr]       <= buf_rdata;
      mem_last[wr_ptr]  <= inflight_last;
      mem_final[wr_ptr] <= inflight_final;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_act_read_sequencer.sv
`default_nettype none
// tb_act_read_sequencer -- table-driven and randomized checks against a queue-based reference model.
module tb_act_read_sequencer;

  logic          clk;
  logic          rst, start, abort;
  logic [15:0]   cfg_base, cfg_stride, cfg_len, cfg_passes;
  logic [15:0]   buf_addr;
  logic          buf_rd;
  logic [127:0]  buf_rdata;
  logic          out_valid, out_ready, out_last, busy, done;
  logic [127:0]  out_data;

  act_read_sequencer #(.DATA_WIDTH(128), .ADDR_WIDTH(16), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_len(cfg_len), .cfg_passes(cfg_passes),
    .buf_addr(buf_addr), .buf_rd(buf_rd), .buf_rdata(buf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5a5a, a + 16'd7, a ^ 16'hc3c3, {a[7:0], a[15:8]}, a - 16'd1, a ^ 16'hbeef};
  endfunction

  // Buffer model: one-cycle read latency, garbage whenever nothing was read.
  always @(posedge clk)
    buf_rdata <= buf_rd ? pat(buf_addr) : {$urandom, $urandom, $urandom, $urandom};

  int total, bad, cyc;

  // Reference model state
  bit           m_active, m_done_now, prev_stall, prev_last, seen_valid;
  logic [127:0] prev_data;
  logic [15:0]  q_addr [$];
  logic [127:0] q_data [$];
  bit           q_last [$];
  int issued, accepted;
  int st_rd, st_vec, st_last, st_first, st_done, st_gaps, st_rd_first, st_rd_last, start_cyc;

  typedef struct {
    logic [15:0] base, stride, len, passes;
    int exp_vec, exp_last, exp_first, exp_done;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    st_rd = 0; st_vec = 0; st_last = 0; st_first = -1; st_done = -1; st_gaps = 0;
    st_rd_first = -1; st_rd_last = -1; seen_valid = 0; issued = 0; accepted = 0;
  endtask

  task automatic load_model();
    for (int p = 0; p < int'(cfg_passes); p++)
      for (int i = 0; i < int'(cfg_len); i++) begin
        logic [15:0] a;
        a = cfg_base + cfg_stride * 16'(i);
        q_addr.push_back(a);
        q_data.push_back(pat(a));
        q_last.push_back(i == int'(cfg_len) - 1);
      end
  endtask

  // One clock cycle: inputs already applied at the falling edge; check, then advance the model.
  task automatic tick();
    bit hs, fin, nd;
    #1;
    cyc++;
    hs = out_valid && out_ready;
    chk("done", done, m_done_now);
    chk("busy", busy, m_active);
    if (!m_active) begin
      chk("rd_when_idle", buf_rd, 1'b0);
      chk("valid_when_idle", out_valid, 1'b0);
    end
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, prev_data);
      chk("hold_last", out_last, prev_last);
    end
    if (buf_rd === 1'b1) begin
      issued++; st_rd++;
      if (st_rd_first < 0) st_rd_first = cyc;
      st_rd_last = cyc;
      if (q_addr.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_extra: read of %0h issued, no read expected", buf_addr);
      end else chk("addr", buf_addr, q_addr.pop_front());
    end
    fin = 0;
    if (hs) begin
      accepted++; st_vec++;
      if (out_last) st_last++;
      if (q_data.size() == 0) begin
        total++; bad++;
        $display("FAIL vec_extra: vector %0h delivered, none expected", out_data);
      end else begin
        chk("data", out_data, q_data.pop_front());
        chk("last", out_last, q_last.pop_front());
      end
      fin = m_active && q_data.size() == 0 && q_addr.size() == 0;
    end
    if (buf_rd === 1'b1) chk("outstanding_le2", (issued - accepted) <= 2, 1'b1);
    if (out_valid === 1'b1 && !seen_valid) begin
      seen_valid = 1;
      st_first = cyc - start_cyc;
    end else if (seen_valid && m_active && out_valid !== 1'b1) st_gaps++;
    if (done === 1'b1) st_done = cyc - start_cyc;
    prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1) && !rst && !abort;
    prev_data  = out_data;
    prev_last  = out_last;
    nd = 0;
    if (rst || abort) begin
      m_active = 0;
      q_addr.delete(); q_data.delete(); q_last.delete();
    end else if (fin) begin
      m_active = 0;
      nd = 1;
    end else if (start && !m_active && !m_done_now) begin
      start_cyc = cyc;
      clear_stats();
      if (cfg_len == 16'd0 || cfg_passes == 16'd0) nd = 1;
      else begin
        m_active = 1;
        load_model();
      end
    end
    m_done_now = nd;
    @(negedge clk);
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run(input int budget, input bit rand_ready);
    int n = 0;
    while ((m_active || m_done_now) && n < budget) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (m_active || m_done_now) begin
      total++; bad++;
      $display("FAIL run_timeout: still running after %0d cycles, want done", budget);
    end
  endtask

  task automatic set_cfg(input logic [15:0] b, input logic [15:0] s, input logic [15:0] l, input logic [15:0] p);
    cfg_base = b; cfg_stride = s; cfg_len = l; cfg_passes = p;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h0010, 16'd1,    16'd4, 16'd1, 4, 1,  3, 7};
    tbl[1] = '{16'hFFFE, 16'd3,    16'd3, 16'd2, 6, 2,  3, 9};
    tbl[2] = '{16'h0100, 16'd1,    16'd0, 16'd5, 0, 0, -1, 1};
    tbl[3] = '{16'h0100, 16'd1,    16'd5, 16'd0, 0, 0, -1, 1};
    tbl[4] = '{16'h1234, 16'h0100, 16'd1, 16'd3, 3, 3,  3, 6};
    tbl[5] = '{16'h0040, 16'd0,    16'd2, 16'd2, 4, 2,  3, 7};

    total = 0; bad = 0; cyc = 0;
    m_active = 0; m_done_now = 0; prev_stall = 0;
    clear_stats();
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    set_cfg(16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_buf_addr", buf_addr, 16'h0);
    chk("rst_buf_rd", buf_rd, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table with out_ready held high: exact latency and no bubbles.
    for (int k = 0; k < 6; k++) begin
      out_ready = 1'b1;
      set_cfg(tbl[k].base, tbl[k].stride, tbl[k].len, tbl[k].passes);
      start_run();
      run(100, 1'b0);
      chk("t_nvec", st_vec, tbl[k].exp_vec);
      chk("t_nrd", st_rd, tbl[k].exp_vec);
      chk("t_nlast", st_last, tbl[k].exp_last);
      chk("t_first_valid", st_first, tbl[k].exp_first);
      chk("t_done_lat", st_done, tbl[k].exp_done);
      chk("t_gaps", st_gaps, 0);
      if (tbl[k].exp_vec > 0) chk("t_rd_span", st_rd_last - st_rd_first + 1, tbl[k].exp_vec);
      tick();
    end

    // len=8 under random backpressure.
    set_cfg(16'($urandom), 16'($urandom_range(1, 300)), 16'd8, 16'd1);
    start_run();
    run(300, 1'b1);
    chk("r8_nvec", st_vec, 8);
    chk("r8_nlast", st_last, 1);
    out_ready = 1'b1;
    tick();

    // Randomized configurations against the reference model.
    for (int k = 0; k < 8; k++) begin
      int l, p;
      l = $urandom_range(1, 6);
      p = $urandom_range(1, 3);
      set_cfg(16'($urandom), (k == 3) ? 16'd0 : 16'($urandom), 16'(l), 16'(p));
      start_run();
      run(300, 1'b1);
      chk("rnd_nvec", st_vec, l * p);
      chk("rnd_nlast", st_last, p);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end

    // Abort with the FIFO full and reads stalled.
    out_ready = 1'b0;
    set_cfg(16'h0200, 16'd2, 16'd6, 16'd1);
    start_run();
    repeat (4) tick();
    chk("ab_buffered", out_valid, 1'b1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_busy", busy, 1'b0);
    chk("ab_valid", out_valid, 1'b0);
    chk("ab_rd", buf_rd, 1'b0);
    repeat (3) tick();
    out_ready = 1'b1;
    set_cfg(16'h0300, 16'd1, 16'd2, 16'd1);
    start_run();
    run(50, 1'b0);
    chk("ab_fresh_nvec", st_vec, 2);
    tick();

    // start during RUN with a different config is ignored.
    out_ready = 1'b1;
    set_cfg(16'h4000, 16'h0010, 16'd5, 16'd2);
    start_run();
    set_cfg(16'h7777, 16'd1, 16'd1, 16'd1);
    start_run();
    run(100, 1'b0);
    chk("rs_nvec", st_vec, 10);
    chk("rs_done_lat", st_done, 13);
    tick();

    // Reset mid-run, then a normal run.
    out_ready = 1'b0;
    set_cfg(16'h0900, 16'd4, 16'd6, 16'd1);
    start_run();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rm_buf_addr", buf_addr, 16'h0);
    chk("rm_buf_rd", buf_rd, 1'b0);
    chk("rm_out_valid", out_valid, 1'b0);
    chk("rm_out_data", out_data, 128'h0);
    chk("rm_out_last", out_last, 1'b0);
    chk("rm_busy", busy, 1'b0);
    chk("rm_done", done, 1'b0);
    tick();
    out_ready = 1'b1;
    set_cfg(16'h0050, 16'd1, 16'd3, 16'd1);
    start_run();
    run(50, 1'b0);
    chk("rm_nvec", st_vec, 3);
    chk("rm_done_lat", st_done, 6);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
